// File: rtl/char_string_render.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : char_string_render                                           |
// | Description : Pipelined renderer for a row of N_CHARS 5x8-cell glyphs      |
// |               (digits 0-9, letters A-Z, blank) at a runtime position.      |
// |               Codes are written into a shadow buffer through a valid/ready |
// |               port and committed to the display buffer on frame_tick, so   |
// |               the screen never tears.                                      |
// | Ports       : clk, reset (sync, active-high)                               |
// |               start_x/start_y : top-left pixel of slot 0                   |
// |               x/y             : current raster position                    |
// |               frame_tick      : commit shadow buffer, advance blink        |
// |               wr_valid/wr_ready/wr_idx/wr_code/wr_blink : slot write port  |
// |               display         : pixel lit, two cycles after x/y sampled    |
// | Options     : CHAR_STRING_BLINK_EN enables the per-slot blink attribute    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module char_string_render #(
  parameter int N_CHARS      = 4,
  parameter int SCALE_LOG2   = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] start_x,
  input  logic [9:0] start_y,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_tick,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_idx,
  input  logic [5:0] wr_code,
  input  logic       wr_blink,
  output logic       display
);

  localparam logic [5:0] BLANK_CODE = 6'd63;

  // 8 rows x 5 columns, row 0 in bits [39:35], column 0 is the MSB of a row.
  function automatic logic [39:0] glyph_bits(input logic [5:0] code);
    case (code)
      6'd0:  glyph_bits = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110, 5'b00000};
      6'd1:  glyph_bits = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110, 5'b00000};
      6'd2:  glyph_bits = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111, 5'b00000};
      6'd3:  glyph_bits = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110, 5'b00000};
      6'd4:  glyph_bits = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010, 5'b00000};
      6'd5:  glyph_bits = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110, 5'b00000};
      6'd6:  glyph_bits = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110, 5'b00000};
      6'd7:  glyph_bits = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
      6'd8:  glyph_bits = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b00000};
      6'd9:  glyph_bits = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100, 5'b00000};
      6'd10: glyph_bits = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b00000};
      6'd11: glyph_bits = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b00000};
      6'd12: glyph_bits = {5'b01110, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b01110, 5'b00000};
      6'd13: glyph_bits = {5'b11100, 5'b10010, 5'b10001, 5'b10001, 5'b10001, 5'b10010, 5'b11100, 5'b00000};
      6'd14: glyph_bits = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111, 5'b00000};
      6'd15: glyph_bits = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b10000, 5'b00000};
      6'd16: glyph_bits = {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01111, 5'b00000};
      6'd17: glyph_bits = {5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b00000};
      6'd18: glyph_bits = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110, 5'b00000};
      6'd19: glyph_bits = {5'b00111, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b10010, 5'b01100, 5'b00000};
      6'd20: glyph_bits = {5'b10001, 5'b10010, 5'b10100, 5'b11000, 5'b10100, 5'b10010, 5'b10001, 5'b00000};
      6'd21: glyph_bits = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111, 5'b00000};
      6'd22: glyph_bits = {5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001, 5'b00000};
      6'd23: glyph_bits = {5'b10001, 5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001, 5'b00000};
      6'd24: glyph_bits = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110, 5'b00000};
      6'd25: glyph_bits = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000, 5'b00000};
      6'd26: glyph_bits = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10010, 5'b01101, 5'b00000};
      6'd27: glyph_bits = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001, 5'b00000};
      6'd28: glyph_bits = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110, 5'b00000};
      6'd29: glyph_bits = {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
      6'd30: glyph_bits = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110, 5'b00000};
      6'd31: glyph_bits = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b00000};
      6'd32: glyph_bits = {5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010, 5'b00000};
      6'd33: glyph_bits = {5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b01010, 5'b10001, 5'b10001, 5'b00000};
      6'd34: glyph_bits = {5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
      6'd35: glyph_bits = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11111, 5'b00000};
      default: glyph_bits = 40'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------- buffers
  logic [5:0] shadow_code_q  [N_CHARS];
  logic [5:0] shadow_code_d  [N_CHARS];
  logic       shadow_blink_q [N_CHARS];
  logic       shadow_blink_d [N_CHARS];
  logic [5:0] disp_code_q    [N_CHARS];
  logic [5:0] disp_code_d    [N_CHARS];
  logic       disp_blink_q   [N_CHARS];
  logic       disp_blink_d   [N_CHARS];

  assign wr_ready = !reset && !frame_tick;

  always_comb begin
    shadow_code_d  = shadow_code_q;
    shadow_blink_d = shadow_blink_q;
    disp_code_d    = disp_code_q;
    disp_blink_d   = disp_blink_q;
    if (frame_tick) begin
      disp_code_d  = shadow_code_q;
      disp_blink_d = shadow_blink_q;
    end
    // Out-of-range indices match no slot, so such writes are simply dropped.
    if (wr_valid && wr_ready) begin
      for (int i = 0; i < N_CHARS; i++) begin
        if (wr_idx == 4'(i)) begin
          shadow_code_d[i]  = wr_code;
          shadow_blink_d[i] = wr_blink;
        end
      end
    end
  end

  // ------------------------------------------------------------ blink phase
  logic blink_on_w;

`ifdef CHAR_STRING_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_tick) begin
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on_w = blink_on_q;
`else
  // Blink attribute is still stored; with the phase pinned on it never hides.
  assign blink_on_w = 1'b1;
`endif

  // ---------------------------------------------------- stage 1: geometry
  // Differences only matter when x >= start_x and y >= start_y, so 10 bits
  // carry the full offset without any wrap-around reaching the screen.
  logic [9:0] dx_w, dy_w, cell_col_w, cell_row_w, slot_w;
  logic [2:0] col_w;
  logic [5:0] code_w;
  logic       blink_w;

  logic       s1_valid_q, s1_valid_d;
  logic       s1_vis_q,   s1_vis_d;
  logic [5:0] s1_code_q,  s1_code_d;
  logic [2:0] s1_row_q,   s1_row_d;
  logic [2:0] s1_col_q,   s1_col_d;

  always_comb begin
    dx_w       = x - start_x;
    dy_w       = y - start_y;
    cell_col_w = dx_w >> SCALE_LOG2;
    cell_row_w = dy_w >> SCALE_LOG2;
    slot_w     = cell_col_w / 10'd6;
    col_w      = 3'(cell_col_w % 10'd6);
    code_w     = BLANK_CODE;
    blink_w    = 1'b0;
    for (int i = 0; i < N_CHARS; i++) begin
      if (slot_w == 10'(i)) begin
        code_w  = disp_code_q[i];
        blink_w = disp_blink_q[i];
      end
    end
    // The slot's code and visibility are captured here so a commit or blink
    // toggle never splits a pixel already in flight.
    s1_valid_d = (x >= start_x) && (y >= start_y) && (slot_w < 10'(N_CHARS)) &&
                 (col_w < 3'd5) && (cell_row_w < 10'd8);
    s1_vis_d   = !blink_w || blink_on_w;
    s1_code_d  = code_w;
    s1_row_d   = cell_row_w[2:0];
    s1_col_d   = col_w;
  end

  // ------------------------------------------------- stage 2: ROM lookup
  logic [39:0] glyph_w;
  logic [5:0]  bit_idx_w;
  logic        display_q, display_d;

  always_comb begin
    glyph_w   = glyph_bits(s1_code_q);
    bit_idx_w = 6'd39 - (6'(s1_row_q) * 6'd5 + 6'(s1_col_q));
    display_d = s1_valid_q && s1_vis_q && glyph_w[bit_idx_w];
  end

  assign display = display_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CHARS; i++) begin
        shadow_code_q[i]  <= BLANK_CODE;
        shadow_blink_q[i] <= 1'b0;
        disp_code_q[i]    <= BLANK_CODE;
        disp_blink_q[i]   <= 1'b0;
      end
      s1_valid_q <= 1'b0;
      s1_vis_q   <= 1'b0;
      s1_code_q  <= BLANK_CODE;
      s1_row_q   <= 3'd0;
      s1_col_q   <= 3'd0;
      display_q  <= 1'b0;
    end else begin
      shadow_code_q  <= shadow_code_d;
      shadow_blink_q <= shadow_blink_d;
      disp_code_q    <= disp_code_d;
      disp_blink_q   <= disp_blink_d;
      s1_valid_q     <= s1_valid_d;
      s1_vis_q       <= s1_vis_d;
      s1_code_q      <= s1_code_d;
      s1_row_q       <= s1_row_d;
      s1_col_q       <= s1_col_d;
      display_q      <= display_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_char_string_render.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_char_string_render                                        |
// | Description : Self-checking bench for char_string_render. A glyph-level    |
// |               model predicts every display pixel two cycles after its      |
// |               x/y, and directed probes pin known pixels of known glyphs.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_char_string_render;

  localparam int N_CHARS      = 4;
  localparam int SCALE_LOG2   = 2;
  localparam int BLINK_FRAMES = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] start_x = 10'd100;
  logic [9:0] start_y = 10'd50;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic       frame_tick = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_idx = 4'd0;
  logic [5:0] wr_code = 6'd0;
  logic       wr_blink = 1'b0;
  logic       display;

  always #5 clk = ~clk;

  char_string_render #(
    .N_CHARS     (N_CHARS),
    .SCALE_LOG2  (SCALE_LOG2),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_x   (start_x),
    .start_y   (start_y),
    .x         (x),
    .y         (y),
    .frame_tick(frame_tick),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_idx    (wr_idx),
    .wr_code   (wr_code),
    .wr_blink  (wr_blink),
    .display   (display)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic act, input logic expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %b, expected %b at t=%0t", name, act, expv, $time);
  endtask

  // ----------------------------------------------------------------- model
  int m_code [N_CHARS];
  bit m_blk  [N_CHARS];
  int m_dcode[N_CHARS];
  bit m_dblk [N_CHARS];
  int m_ticks;
  bit exp1, exp2;

  // Bitmaps of the glyphs this bench draws; any other code renders blank.
  function automatic bit [4:0] font_row(input int code, input int r);
    bit [4:0] rows [8];
    case (code)
      1:  rows = '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110, 5'b00000};
      7:  rows = '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
      8:  rows = '{5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b00000};
      10: rows = '{5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b00000};
      default: rows = '{default: 5'b00000};
    endcase
    return rows[r];
  endfunction

  function automatic bit phase_on();
`ifdef CHAR_STRING_BLINK_EN
    return ((m_ticks / BLINK_FRAMES) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit model_pixel(input int px, input int py, input int sx, input int sy);
    int cc, cr, slot, col;
    bit [4:0] row;
    if (px < sx || py < sy) return 1'b0;
    cc   = (px - sx) / (1 << SCALE_LOG2);
    cr   = (py - sy) / (1 << SCALE_LOG2);
    slot = cc / 6;
    col  = cc % 6;
    if (slot >= N_CHARS || col >= 5 || cr >= 8) return 1'b0;
    if (m_dblk[slot] && !phase_on()) return 1'b0;
    row = font_row(m_dcode[slot], cr);
    return row[4 - col];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp1    <= 1'b0;
      exp2    <= 1'b0;
      m_ticks <= 0;
      for (int i = 0; i < N_CHARS; i++) begin
        m_code[i]  <= 63;
        m_blk[i]   <= 1'b0;
        m_dcode[i] <= 63;
        m_dblk[i]  <= 1'b0;
      end
    end else begin
      exp1 <= model_pixel(int'(x), int'(y), int'(start_x), int'(start_y));
      exp2 <= exp1;
      if (frame_tick) begin
        m_dcode <= m_code;
        m_dblk  <= m_blk;
        m_ticks <= m_ticks + 1;
      end
      if (wr_valid && !frame_tick && int'(wr_idx) < N_CHARS) begin
        m_code[int'(wr_idx)] <= int'(wr_code);
        m_blk[int'(wr_idx)]  <= wr_blink;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("display_vs_model", display, exp2);
      check("wr_ready_vs_model", wr_ready, !reset && !frame_tick);
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_write(input int idx, input int code, input bit blk);
    bit done = 1'b0;
    wr_valid = 1'b1;
    wr_idx   = 4'(idx);
    wr_code  = 6'(code);
    wr_blink = blk;
    for (int k = 0; k < 8 && !done; k++) begin
      @(posedge clk);
      done = wr_ready;
      #1;
    end
    wr_valid = 1'b0;
    check("write_accepted", done, 1'b1);
  endtask

  task automatic probe(input string name, input int px, input int py, input bit expv);
    x = 10'(px);
    y = 10'(py);
    step();
    step();
    @(negedge clk);
    check(name, display, expv);
  endtask

  // Raster over [x0,x1) x [y0,y1); reset is held for three cycles from
  // pixel number rst_at when rst_at >= 0.
  task automatic scan(input int x0, input int x1, input int y0, input int y1, input int rst_at);
    int n = 0;
    for (int yy = y0; yy < y1; yy++) begin
      for (int xx = x0; xx < x1; xx++) begin
        x = 10'(xx);
        y = 10'(yy);
        if (rst_at >= 0 && n == rst_at)     reset = 1'b1;
        if (rst_at >= 0 && n == rst_at + 3) reset = 1'b0;
        step();
        if (rst_at >= 0 && n == rst_at) begin
          @(negedge clk);
          check("reset_clears_display", display, 1'b0);
        end
        n++;
      end
    end
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    step();
    check_en = 1'b1;
    frame_tick = 1'b1;           // ignored while in reset
    step();
    frame_tick = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", wr_ready, 1'b1);

    // Blank screen after reset.
    scan(96, 196, 46, 86, -1);

    // "1" in slot 0 and "A" in slot 2.
    do_write(0, 1, 1'b0);
    do_write(2, 10, 1'b0);
    probe("before_commit_blank", 108, 50, 1'b0);
    pulse_tick();
    probe("one_r0_c2_lit", 108, 50, 1'b1);
    probe("one_r0_c0_off", 100, 50, 1'b0);
    probe("gap_col_off", 120, 54, 1'b0);
    probe("slot1_blank", 128, 62, 1'b0);
    probe("a_r0_c1_lit", 152, 50, 1'b1);
    probe("a_r0_c0_off", 148, 50, 1'b0);
    probe("a_r3_c0_lit", 148, 62, 1'b1);
    scan(96, 196, 46, 86, -1);

    // Write held across a frame_tick is stalled, then accepted.
    frame_tick = 1'b1;
    wr_valid   = 1'b1;
    wr_idx     = 4'd3;
    wr_code    = 6'd7;
    wr_blink   = 1'b0;
    @(negedge clk);
    check("stall_ready_low", wr_ready, 1'b0);
    step();
    frame_tick = 1'b0;
    @(negedge clk);
    check("stall_then_ready", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
    probe("seven_pending", 172, 50, 1'b0);
    pulse_tick();
    probe("seven_shown", 172, 50, 1'b1);
    scan(96, 196, 46, 86, -1);

    // No wrap-around when start_x is near the right edge.
    start_x = 10'd1010;
    probe("no_wrap_x5", 5, 50, 1'b0);
    scan(0, 40, 46, 86, -1);
    scan(1000, 1024, 46, 86, -1);
    start_x = 10'd100;

    // Out-of-range slot index is accepted and discarded.
    do_write(9, 5, 1'b0);
    pulse_tick();
    probe("idx9_slot0_kept", 108, 50, 1'b1);
    probe("idx9_slot3_kept", 172, 50, 1'b1);
    scan(96, 196, 46, 86, -1);

    // Blink: commit on the 4th tick after reset, then six frames.
    do_reset();
    pulse_tick();
    pulse_tick();
    pulse_tick();
    do_write(0, 8, 1'b1);
    pulse_tick();
    for (int f = 0; f < 6; f++) begin
`ifdef CHAR_STRING_BLINK_EN
      probe($sformatf("blink_frame%0d", f), 104, 50, ((f / 2) % 2) == 0);
`else
      probe($sformatf("blink_frame%0d", f), 104, 50, 1'b1);
`endif
      pulse_tick();
    end

    // Reset in the middle of a scan with text on screen.
    do_reset();
    do_write(0, 8, 1'b0);
    pulse_tick();
    probe("pre_reset_shown", 104, 50, 1'b1);
    scan(96, 196, 46, 86, 500);
    probe("post_reset_blank", 104, 50, 1'b0);
    do_write(0, 8, 1'b0);
    pulse_tick();
    probe("rewrite_shown", 104, 50, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
